// File: rtl/imem_loader.sv
// Boot loader: assembles big-endian words from a byte stream and writes them to instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to add a trailing mod-256 checksum byte with CHECK/FAIL states.
module imem_loader #(
  parameter int AW    = 6,
  parameter int WORDS = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_wd,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, FAIL} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  localparam logic [AW-1:0] LAST_W = AW'(WORDS - 1);
  localparam logic [AW-1:0] ONE_W  = AW'(1);

  state_t        state, state_nxt;
  logic [1:0]    byte_cnt;
  logic [AW-1:0] word_cnt;
  logic [23:0]   shreg;
  logic          full;
  logic          enter_load;
  logic          img_hs;

  assign img_hs = rx_valid && rx_ready && (state == LOAD);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_chk;
  assign sum_chk = sum + rx_data;
  assign err     = (state == FAIL);
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    enter_load = 1'b0;
    rx_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cpu_hold   = 1'b1;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = LOAD;
          enter_load = 1'b1;
        end
      end
      LOAD: begin
        rx_ready = !full;
        busy     = 1'b1;
        // leave only once the final word's write strobe is on the bus
        if (full && mem_we) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
        if (rx_valid) state_nxt = (sum_chk == 8'h00) ? DONE : FAIL;
      end
      FAIL: begin
        if (start) begin
          state_nxt  = LOAD;
          enter_load = 1'b1;
        end
      end
`endif
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) begin
          state_nxt  = LOAD;
          enter_load = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= 2'd0;
      word_cnt <= '0;
      shreg    <= '0;
      full     <= 1'b0;
      mem_we   <= 1'b0;
      mem_a    <= '0;
      mem_wd   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum      <= 8'h00;
`endif
    end else begin
      mem_we <= 1'b0;
      if (enter_load) begin
        byte_cnt <= 2'd0;
        word_cnt <= '0;
        shreg    <= '0;
        full     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum      <= 8'h00;
`endif
      end else if (img_hs) begin
        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum      <= sum_chk;
`endif
        if (byte_cnt == 2'd3) begin
          mem_we <= 1'b1;
          mem_a  <= word_cnt;
          mem_wd <= {shreg, rx_data};
          shreg  <= '0;
          if (word_cnt == LAST_W) full <= 1'b1;
          else                    word_cnt <= word_cnt + ONE_W;
        end else begin
          shreg <= {shreg[15:0], rx_data};
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (WORDS=4): table vectors, corner sequences and random images.
module tb_imem_loader;
  localparam int AW    = 6;
  localparam int WORDS = 4;
  localparam int NB    = WORDS * 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready, mem_we, cpu_hold, busy, done, err;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_wd;

  imem_loader #(.AW(AW), .WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   wd;
  } wr_t;
  wr_t wq[$];

  always @(negedge clk) if (mem_we === 1'b1) wq.push_back('{a: mem_a, wd: mem_wd});

  int total = 0;
  int passed = 0;
  logic [7:0]  img   [NB];
  logic [31:0] exp_w [WORDS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) $display("FAIL %s: got %h expected %h", name, act, expv);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = rx_ready;
      tick();
    end
    rx_valid = 1'b0;
    if (!ok) begin
      total++;
      $display("FAIL handshake: got timeout expected accept of %h", b);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_writes(input string tag);
    chk({tag, " nwrites"}, wq.size(), WORDS);
    for (int i = 0; i < WORDS; i++) begin
      if (i < wq.size()) begin
        chk({tag, " addr"}, 32'(wq[i].a), i);
        chk({tag, " data"}, wq[i].wd, exp_w[i]);
      end
    end
  endtask

  // mode 0: back-to-back, 1: one idle cycle before each byte, 2: random gaps
  task automatic do_load(input string tag, input int mode, input logic [7:0] cb, input logic exp_pass);
    wq.delete();
    pulse_start();
    @(negedge clk);
    chk({tag, " hold after start"}, cpu_hold, 1);
    chk({tag, " done after start"}, done, 0);
    chk({tag, " err after start"}, err, 0);
    chk({tag, " busy after start"}, busy, 1);
    tick();
    for (int i = 0; i < NB; i++) begin
      int gap;
      gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
      repeat (gap) tick();
      send_byte(img[i]);
    end
    @(negedge clk);
    chk({tag, " last mem_we"}, mem_we, 1);
    chk({tag, " done during write"}, done, 0);
    chk({tag, " hold during write"}, cpu_hold, 1);
    tick();
    @(negedge clk);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk({tag, " check busy"}, busy, 1);
    chk({tag, " check ready"}, rx_ready, 1);
    tick();
    send_byte(cb);
    @(negedge clk);
    chk({tag, " done"}, done, exp_pass);
    chk({tag, " err"}, err, !exp_pass);
    chk({tag, " hold"}, cpu_hold, !exp_pass);
`else
    chk({tag, " done"}, done, 1);
    chk({tag, " hold"}, cpu_hold, 0);
    chk({tag, " err"}, err, 0);
`endif
    chk({tag, " ready idle"}, rx_ready, 0);
    chk({tag, " busy idle"}, busy, 0);
    tick();
    check_writes(tag);
  endtask

  // reference model: words are the bytes taken four at a time, first byte most significant
  task automatic model_words();
    for (int i = 0; i < WORDS; i++)
      exp_w[i] = (32'(img[4*i]) << 24) | (32'(img[4*i+1]) << 16) | (32'(img[4*i+2]) << 8) | 32'(img[4*i+3]);
  endtask

  function automatic int image_sum();
    int s;
    s = 0;
    for (int i = 0; i < NB; i++) s += int'(img[i]);
    return s % 256;
  endfunction

  typedef struct {
    logic [127:0] bytes;
    int           mode;
    logic [7:0]   cb;
    logic [31:0]  w0, w1, w2, w3;
    logic         exp_pass;
  } vec_t;

  vec_t vec [4];

  initial begin
    vec[0] = '{bytes: 128'h20020005_20020005_20020005_20020005, mode: 0, cb: 8'h64,
               w0: 32'h20020005, w1: 32'h20020005, w2: 32'h20020005, w3: 32'h20020005, exp_pass: 1'b1};
    vec[1] = '{bytes: 128'h20020005_20020005_20020005_20020005, mode: 1, cb: 8'h00,
               w0: 32'h20020005, w1: 32'h20020005, w2: 32'h20020005, w3: 32'h20020005, exp_pass: 1'b0};
    vec[2] = '{bytes: 128'h01020304_05060708_090A0B0C_0D0E0F10, mode: 0, cb: 8'h78,
               w0: 32'h01020304, w1: 32'h05060708, w2: 32'h090A0B0C, w3: 32'h0D0E0F10, exp_pass: 1'b1};
    vec[3] = '{bytes: 128'hDEADBEEF_FFFFFFFF_00000000_80000001, mode: 1, cb: 8'h4C,
               w0: 32'hDEADBEEF, w1: 32'hFFFFFFFF, w2: 32'h00000000, w3: 32'h80000001, exp_pass: 1'b0};

    // reset values
    repeat (2) tick();
    @(negedge clk);
    chk("reset rx_ready", rx_ready, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset mem_a", 32'(mem_a), 0);
    chk("reset mem_wd", mem_wd, 0);
    chk("reset cpu_hold", cpu_hold, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    tick();
    reset = 1'b0;
    tick();

    // table vectors
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < NB; i++) img[i] = vec[v].bytes[127 - 8*i -: 8];
      exp_w[0] = vec[v].w0; exp_w[1] = vec[v].w1; exp_w[2] = vec[v].w2; exp_w[3] = vec[v].w3;
      do_load($sformatf("vec%0d", v), vec[v].mode, vec[v].cb, vec[v].exp_pass);
    end

    // start during LOAD is ignored and the word counter carries on
    for (int i = 0; i < NB; i++) img[i] = 8'(8'h30 + i);
    model_words();
    wq.delete();
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(img[i]);
    pulse_start();
    @(negedge clk);
    chk("midstart busy", busy, 1);
    tick();
    for (int i = 5; i < NB; i++) send_byte(img[i]);
    repeat (2) tick();
    check_writes("midstart");
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'(256 - image_sum()));
    @(negedge clk);
    chk("midstart done", done, 1);
    tick();
`endif

    // reset after 6 bytes discards the partial word
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(img[i]);
    tick();
    wq.delete();
    reset = 1'b1;
    @(negedge clk);
    chk("midreset busy", busy, 0);
    chk("midreset rx_ready", rx_ready, 0);
    chk("midreset hold", cpu_hold, 1);
    chk("midreset mem_a", 32'(mem_a), 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("midreset no write", wq.size(), 0);
    for (int i = 0; i < NB; i++) img[i] = 8'(8'hA0 ^ i);
    model_words();
    do_load("after reset", 0, 8'(256 - image_sum()), 1'b1);

    // randomized images against the model
    for (int r = 0; r < 6; r++) begin
      logic       pass;
      logic [7:0] cb;
      for (int i = 0; i < NB; i++) img[i] = 8'($urandom);
      model_words();
      pass = 1'($urandom_range(0, 1));
      cb = pass ? 8'(256 - image_sum()) : 8'($urandom);
      if (!pass && ((image_sum() + int'(cb)) % 256 == 0)) cb = cb + 8'd1;
      do_load($sformatf("rand%0d", r), 2, cb, pass);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the 64×32 instruction memory of the single-cycle CPU. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Each word is written through the memory's write port at consecutive word addresses. The CPU is held in reset until a full image has been written.

## Interface
- `AW`, default 6: word-address width; matches the 64-word instruction memory.
- `WORDS`, default 64: words per image; legal range 1 to 2^AW.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  single-cycle pulse that begins a load; honoured in IDLE, DONE and FAIL, ignored elsewhere.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  one-cycle instruction-memory write strobe.
- `mem_a`  out  AW  word address of the write.
- `mem_wd`  out  32  write data.
- `cpu_hold`  out  1  drives CPU reset; high until a good image is loaded.
- `busy`  out  1  load in progress.
- `done`  out  1  image loaded successfully.
- `err`  out  1  checksum failure; constant 0 when the checksum is not compiled in.

## Operation
- **Reset values:** state IDLE, `rx_ready`=0, `mem_we`=0, `mem_a`=0, `mem_wd`=0, `cpu_hold`=1, `busy`=0, `done`=0, `err`=0. All counters and the shift register are 0.
- **States and transitions:**
  - IDLE → LOAD on `start`.
  - LOAD → CHECK after the final write, when the checksum is compiled in.
  - LOAD → DONE after the final write otherwise.
  - CHECK → DONE on a checksum pass.
  - CHECK → FAIL on a checksum mismatch.
  - DONE or FAIL → LOAD on `start`.
- **Byte handshake:** a byte transfers when `rx_valid` and `rx_ready` are both high. `rx_ready` = 1 in LOAD until all WORDS×4 bytes are accepted, and = 1 in CHECK until its single byte is accepted. It is 0 otherwise.
- **Word assembly:**
  - The first byte of each word goes to bits [31:24] and the fourth byte to bits [7:0].
  - A 2-bit byte counter wraps from 3 to 0.
  - The word counter runs 0 to WORDS−1. It does not wrap within a load and resets to 0 on entry to LOAD.
- **Write:**
  - `mem_we` is asserted for exactly one cycle, in the cycle after the handshake of a word's fourth byte.
  - During that cycle `mem_a` holds the word index and `mem_wd` holds the assembled word.
  - `mem_a` and `mem_wd` keep their last values between writes.
- **Status outputs:**
  - `busy` = 1 in LOAD and CHECK.
  - `done` = 1 only in DONE.
  - `cpu_hold` = 0 only in DONE.
  - Entering LOAD from DONE reasserts `cpu_hold` and clears `done` and `err`.
- **Reset mid-load:** any partial word is discarded, no further writes occur, and the loader returns to IDLE. Memory contents already written are not cleared.
- **Simultaneous events:**
  - `start` during LOAD or CHECK is ignored.
  - A `start` in the same cycle as a handshake in DONE has no effect on the data, because `rx_ready` is 0 in DONE.

## Timing
- **Per-word latency:** `mem_we` goes high 1 cycle after the fourth-byte handshake.
- **Throughput:** 1 byte per cycle. A byte handshake may coincide with the `mem_we` cycle of the previous word.
- **Final word:**
  - The fourth-byte handshake occurs at cycle n, and `mem_we` is high at cycle n+1.
  - The state leaves LOAD at the end of cycle n+1.
  - `done`=1 and `cpu_hold`=0 from cycle n+2 when there is no checksum. The CPU is therefore never released during a write.
- **CHECK:**
  - The checksum byte is accepted at cycle m.
  - DONE or FAIL is entered at the end of cycle m.
  - From cycle m+1, either `done` is high, or `err` is high with `cpu_hold` staying high.
- **Minimum load time with back-to-back bytes:** WORDS×4+1 cycles from the first handshake to `done`.

## Configuration
- **`IMEM_LOADER_CHECKSUM_EN` defined:**
  - An 8-bit running sum (mod 256) covers every image byte.
  - The CHECK state accepts one further byte.
  - The image passes if sum + checkbyte ≡ 0 mod 256; otherwise the loader enters FAIL with `err`=1, `cpu_hold`=1 and `done`=0.
- **`IMEM_LOADER_CHECKSUM_EN` undefined:**
  - There is no CHECK or FAIL state and no sum register.
  - `err` is tied to 0, and LOAD goes directly to DONE.

## Test plan
- **Reset values:** assert `reset` → all outputs at their reset values, `cpu_hold`=1, `rx_ready`=0.
- **Basic image (WORDS=4):** `start`, then bytes 0x20,0x02,0x00,0x05 repeated for 4 words, back-to-back → 4 `mem_we` pulses with `mem_a`=0..3 and `mem_wd`=0x20020005, `done`=1 at byte 16 + 2 cycles, then `rx_ready`=0.
- **Throttled source:** `rx_valid` toggled every other cycle with the same image → identical writes; no byte lost or duplicated.
- **Reset mid-load:** `reset` pulsed after 6 bytes, then `start` and a full image → first write after the restart is at `mem_a`=0; no write occurs for the aborted partial word.
- **Checksum (macro on):** image bytes 0x01,0x02,0x03,0x04, then check byte 0xF6 → `done`=1, `err`=0. With check byte 0x00 → `err`=1, `cpu_hold`=1.
- **Reload:** `start` in DONE → `cpu_hold` rises the next cycle and `done`=0. `start` asserted during LOAD → ignored; the word counter is unchanged.
